// File: rtl/seq_compare_if.sv
// seq_compare_if: operand/result handshake bundle for seq_compare.
// master = operand producer and result consumer, slave = the comparator.
interface seq_compare_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             ge;
    logic             le;
    logic             busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, eq, gt, lt, ge, le, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, eq, gt, lt, ge, le, busy
    );
endinterface

// File: rtl/seq_compare.sv
// seq_compare: multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock,
// most significant slice first.  The operands are shifted left each RUN cycle
// so the slice under test is always the top CHUNK bits.
// Optional feature macro: SEQ_COMPARE_EARLY_EXIT_EN (stop at first differing
// slice); when undefined every compare takes exactly N cycles in RUN.
module seq_compare #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_compare_if.slave bus
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic               r_signed, w_signed_nxt;
    logic               r_first, w_first_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_eq, w_eq_nxt;
    logic               r_gt, w_gt_nxt;
    logic               r_lt, w_lt_nxt;
    logic               r_ge, w_ge_nxt;
    logic               r_le, w_le_nxt;
    logic               r_in_ready, w_in_ready_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_busy, w_busy_nxt;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
    logic               r_found, w_found_nxt;
    logic               r_p_gt, w_p_gt_nxt;
    logic               r_p_lt, w_p_lt_nxt;
`endif

    logic [CHUNK-1:0]   w_sa, w_sb, w_flip, w_ka, w_kb;
    logic               w_s_gt, w_s_lt, w_s_diff;

    // Top-slice compare; the MSB slice is biased by flipping its sign bit in signed mode.
    always_comb begin
        w_sa     = r_a[WIDTH-1 -: CHUNK];
        w_sb     = r_b[WIDTH-1 -: CHUNK];
        w_flip   = CHUNK'(r_first & r_signed) << (CHUNK - 1);
        w_ka     = w_sa ^ w_flip;
        w_kb     = w_sb ^ w_flip;
        w_s_gt   = (w_ka > w_kb);
        w_s_lt   = (w_ka < w_kb);
        w_s_diff = (w_sa != w_sb);
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_signed_nxt = r_signed;
        w_first_nxt  = r_first;
        w_cnt_nxt    = r_cnt;
        w_eq_nxt     = r_eq;
        w_gt_nxt     = r_gt;
        w_lt_nxt     = r_lt;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
        w_found_nxt  = r_found;
        w_p_gt_nxt   = r_p_gt;
        w_p_lt_nxt   = r_p_lt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_a_nxt      = bus.a;
                    w_b_nxt      = bus.b;
                    w_signed_nxt = bus.signed_mode;
                    w_first_nxt  = 1'b1;
                    w_cnt_nxt    = CNT_W'(N - 1);
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
                    w_found_nxt  = 1'b0;
`endif
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt     = r_a << CHUNK;
                w_b_nxt     = r_b << CHUNK;
                w_first_nxt = 1'b0;
                w_cnt_nxt   = r_cnt - CNT_W'(1);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
                if (w_s_diff || (r_cnt == '0)) begin
                    w_eq_nxt    = ~w_s_diff;
                    w_gt_nxt    = w_s_gt;
                    w_lt_nxt    = w_s_lt;
                    w_state_nxt = S_DONE;
                end
`else
                if (w_s_diff && !r_found) begin
                    w_found_nxt = 1'b1;
                    w_p_gt_nxt  = w_s_gt;
                    w_p_lt_nxt  = w_s_lt;
                end
                if (r_cnt == '0) begin
                    if (r_found) begin
                        w_eq_nxt = 1'b0;
                        w_gt_nxt = r_p_gt;
                        w_lt_nxt = r_p_lt;
                    end else begin
                        w_eq_nxt = ~w_s_diff;
                        w_gt_nxt = w_s_gt;
                        w_lt_nxt = w_s_lt;
                    end
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_ge_nxt        = w_gt_nxt | w_eq_nxt;
        w_le_nxt        = w_lt_nxt | w_eq_nxt;
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset discards any in-flight compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_ge        <= 1'b0;
            r_le        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
            r_found     <= 1'b0;
            r_p_gt      <= 1'b0;
            r_p_lt      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_signed    <= w_signed_nxt;
            r_first     <= w_first_nxt;
            r_cnt       <= w_cnt_nxt;
            r_eq        <= w_eq_nxt;
            r_gt        <= w_gt_nxt;
            r_lt        <= w_lt_nxt;
            r_ge        <= w_ge_nxt;
            r_le        <= w_le_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
`ifndef SEQ_COMPARE_EARLY_EXIT_EN
            r_found     <= w_found_nxt;
            r_p_gt      <= w_p_gt_nxt;
            r_p_lt      <= w_p_lt_nxt;
`endif
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.eq        = r_eq;
    assign bus.gt        = r_gt;
    assign bus.lt        = r_lt;
    assign bus.ge        = r_ge;
    assign bus.le        = r_le;
endmodule
